conv_encode_frame: RTL

- Parametrised framed convolutional encoder, rate UNC_W+1 / UNC_W+2: UNC_W uncoded bits pass straight through, one coded bit enters a MEM-deep shift register, two tap-selected parity outputs.
- Adds valid/ready handshaking on input and output, a registered output stage, and optional trellis termination: MEM zero tail symbols after in_last return the encoder to state 0.
- Sits between the symbol source and the mapper/decoder bench in the Viterbi chain.
- With default parameters the symbol stream matches the existing 2/3 encoder: Y2=X2, Y1=X1^X1(n-2), Y0=X1(n-1).

---
 rtl/conv_encode_frame.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/conv_encode_frame.sv
// Framed convolutional encoder: UNC_W pass-through bits plus two tap-selected
// parities over a MEM-deep history, with valid/ready handshake and optional zero tail.
module conv_encode_frame #(
    parameter int           UNC_W = 1,
    parameter int           MEM   = 2,
    parameter logic [MEM:0] G1    = 3'b101,
    parameter logic [MEM:0] G0    = 3'b010,
    parameter int           TERM  = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [UNC_W-1:0] in_unc,
    input  logic             in_x,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [UNC_W-1:0] out_unc,
    output logic             out_c1,
    output logic             out_c0,
    output logic             out_last,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(MEM + 1);
    localparam logic [CNT_W-1:0] TAIL_LEN = CNT_W'(MEM);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            TERM_EN  = (TERM != 0);

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } state_t;

    function automatic logic parity_f(input logic [MEM:0] taps);
        return ^taps;
    endfunction

    state_t             state_r, state_s;
    logic [MEM-1:0]     sr_r, sr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               out_valid_r, out_valid_s;
    logic [UNC_W-1:0]   out_unc_r, out_unc_s;
    logic               out_c1_r, out_c1_s;
    logic               out_c0_r, out_c0_s;
    logic               out_last_r, out_last_s;
    logic               busy_r, busy_s;
    logic               in_ready_s;
    logic               load_s;
    logic               x_s;
    logic [MEM:0]       t_s;

    // Next-state, shift register and output-stage logic
    always_comb begin
        state_s     = state_r;
        sr_s        = sr_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r & ~out_ready;
        out_unc_s   = out_unc_r;
        out_c1_s    = out_c1_r;
        out_c0_s    = out_c0_r;
        out_last_s  = out_last_r;
        in_ready_s  = (state_r == ST_DATA) & (~out_valid_r | out_ready);
        load_s      = 1'b0;
        x_s         = 1'b0;

        case (state_r)
            ST_DATA: begin
                x_s    = in_x;
                load_s = in_valid & in_ready_s;
            end
            ST_TAIL: begin
                x_s    = 1'b0;
                load_s = ~out_valid_r | out_ready;
            end
            default: begin
                x_s    = 1'b0;
                load_s = 1'b0;
            end
        endcase

        t_s = {sr_r, x_s};

        if (load_s) begin
            // {sr, x} truncated to MEM bits is the shifted history, valid for MEM == 1 too
            sr_s        = t_s[MEM-1:0];
            out_valid_s = 1'b1;
            out_c1_s    = parity_f(t_s & G1);
            out_c0_s    = parity_f(t_s & G0);
            case (state_r)
                ST_DATA: begin
                    out_unc_s = in_unc;
                    if (in_last && TERM_EN) begin
                        out_last_s = 1'b0;
                        cnt_s      = TAIL_LEN;
                        state_s    = ST_TAIL;
                    end else begin
                        out_last_s = in_last;
                        state_s    = ST_DATA;
                    end
                end
                ST_TAIL: begin
                    out_unc_s = {UNC_W{1'b0}};
                    cnt_s     = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        out_last_s = 1'b1;
                        state_s    = ST_DATA;
                    end else begin
                        out_last_s = 1'b0;
                        state_s    = ST_TAIL;
                    end
                end
                default: begin
                    out_unc_s = {UNC_W{1'b0}};
                    state_s   = ST_DATA;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s == ST_TAIL) | (|sr_s);
    end

    // State and registered output stage
    always_ff @(posedge clk) begin
        if (res) begin
            state_r     <= ST_DATA;
            sr_r        <= {MEM{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_unc_r   <= {UNC_W{1'b0}};
            out_c1_r    <= 1'b0;
            out_c0_r    <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            sr_r        <= sr_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
            out_unc_r   <= out_unc_s;
            out_c1_r    <= out_c1_s;
            out_c0_r    <= out_c0_s;
            out_last_r  <= out_last_s;
            busy_r      <= busy_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_unc   = out_unc_r;
    assign out_c1    = out_c1_r;
    assign out_c0    = out_c0_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule
